plat_addr_gen: RTL and testbench
================================

PLAT_ADDR_GEN -- requirements
Module: plat_addr_gen

Interface
REQ-001 SHALL have parameter SPRITE_H, default 16, meaning sprite height in rows.
REQ-002 SHALL have parameter COORD_W, default 10, meaning the pixel-coordinate width.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports draw_x and draw_y, input, COORD_W each, the current VGA pixel.
REQ-006 SHALL have port pix_valid, input, 1; draw_x/draw_y are valid this cycle.
REQ-007 SHALL have port frame_start, input, 1, a one-cycle pulse at the first pixel of each frame.
REQ-008 SHALL have ports plat_x and plat_y, input, COORD_W each, the requested platform top-left corner.
REQ-009 SHALL have port plat_size, input, 8; legal codes are 128/64/32/16.
REQ-010 SHALL have port upd_req, input, 1, a request to load new platform parameters.
REQ-011 SHALL have port upd_ack, output, 1, a one-cycle pulse when the new parameters go active.
REQ-012 SHALL have port read_address, output, 19, the sprite ROM address.
REQ-013 SHALL have port plat_hit, output, 1; the pixel lies inside the active platform.
REQ-014 SHALL have port out_valid, output, 1, the pipelined pix_valid.

Function
REQ-015 SHALL keep active registers act_x, act_y and act_size, which drive all address and hit arithmetic.
REQ-016 Sprite width SHALL be W = 2*act_size (256/128/64/32 pixels), with height SPRITE_H.
REQ-017 The update FSM SHALL have states IDLE, PENDING and APPLY.
- IDLE + upd_req: capture plat_x/plat_y/plat_size into pending registers, go to PENDING.
- PENDING + frame_start: copy pending into active, go to APPLY.
- APPLY: assert upd_ack for exactly one cycle, then go to IDLE.
REQ-018 upd_req asserted in PENDING or APPLY SHALL be ignored, leaving pending values unchanged; the requester must hold or re-issue it.
REQ-019 upd_req and frame_start together in IDLE SHALL only capture; the new values apply at the next frame_start.
REQ-020 frame_start in IDLE SHALL leave the active registers unchanged.
REQ-021 The pipeline SHALL be two stages, so out_valid, plat_hit and read_address appear 2 cycles after the matching pix_valid.
REQ-022 Stage 1 SHALL register the following, all as unsigned COORD_W+1-bit values computed with wrap-free subtraction:
- dx = draw_x - act_x
- dy = draw_y - act_y
- in-range flag = (draw_x >= act_x) && (dx < W) && (draw_y >= act_y) && (dy < SPRITE_H)
REQ-023 Stage 2 SHALL form read_address = (dy << log2(W)) + dx using shifts only, with no multiplier.
REQ-024 An illegal act_size (not 128/64/32/16) SHALL force plat_hit=0 and read_address=0.
REQ-025 When plat_hit=0 or out_valid=0, read_address SHALL be 0.
REQ-026 A platform clipped at the right or bottom screen edge SHALL give hits only for on-screen pixels, with no address wrap.
REQ-027 The pipeline SHALL advance every cycle; there is no stall input.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously clear:
- read_address=0, plat_hit=0, out_valid=0, upd_ack=0
- FSM to IDLE
- act_x=act_y=0, act_size=0 (no draw)
- pending registers
REQ-029 Reset in PENDING or APPLY SHALL discard the pending update, and no upd_ack SHALL follow.

Configuration
REQ-030 Macro PLAT_HFLIP_EN, when defined, SHALL add input plat_hflip (1 bit), captured and applied with the other parameters.
- When the active flip is set, stage 2 SHALL use W-1-dx in place of dx.
REQ-031 Without PLAT_HFLIP_EN, the plat_hflip port and the flip logic SHALL be absent, and addressing SHALL be unflipped.

Structure
REQ-032 Package plat_pkg SHALL hold:
- the FSM state enum
- SPRITE_H and the size-code constants (128/64/32/16)
- a size-to-log2(W) function that returns an invalid flag
REQ-033 The FSM and the pending/active registers SHALL form sub-module plat_upd_ctrl; the datapath SHALL stay in plat_addr_gen.

Verification
REQ-034 Reset, then upd_req with x=100, y=200, size=64, then frame_start: upd_ack pulses exactly once, 2 cycles after frame_start.
REQ-035 Active x=100, y=200, size=64, pixel (110,203) with pix_valid: 2 cycles later out_valid=1, plat_hit=1, read_address=3*128+10=394.
REQ-036 Same platform, pixels (99,203), (228,203) and (110,216): plat_hit=0 and read_address=0 for each.
REQ-037 upd_req and frame_start in the same cycle, then a second upd_req while PENDING: the first values apply at the next frame_start, and the second request is ignored.
REQ-038 rst_n is pulsed low while PENDING: all outputs read 0, and no upd_ack follows a later frame_start.
REQ-039 size=200 applied: plat_hit=0 for all pixels. With PLAT_HFLIP_EN, flip=1, size=16, pixel dx=0, dy=0: read_address=31.

Source files
------------

// File: rtl/plat_pkg.sv
// plat_pkg: shared types, constants and size decode for the platform address generator
package plat_pkg;
  typedef enum logic [1:0] {IDLE, PENDING, APPLY} upd_state_t;
  localparam int SPRITE_H = 16;
  localparam logic [7:0] SIZE_128 = 8'd128;
  localparam logic [7:0] SIZE_64  = 8'd64;
  localparam logic [7:0] SIZE_32  = 8'd32;
  localparam logic [7:0] SIZE_16  = 8'd16;
  typedef struct packed {
    logic       ok;
    logic [3:0] lg;
  } size_dec_t;
  // Maps a size code to log2 of the sprite width (twice the code); ok=0 for illegal codes
  function automatic size_dec_t size_log2(input logic [7:0] size);
    return (size == SIZE_128) ? size_dec_t'({1'b1, 4'd8}) :
           (size == SIZE_64)  ? size_dec_t'({1'b1, 4'd7}) :
           (size == SIZE_32)  ? size_dec_t'({1'b1, 4'd6}) :
           (size == SIZE_16)  ? size_dec_t'({1'b1, 4'd5}) :
                                size_dec_t'({1'b0, 4'd0});
  endfunction
endpackage

// File: rtl/plat_upd_ctrl.sv
// plat_upd_ctrl: frame-synchronous platform parameter update (pending/active registers); PLAT_HFLIP_EN adds flip
module plat_upd_ctrl
  import plat_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] plat_x,
  input  logic [COORD_W-1:0] plat_y,
  input  logic [7:0]         plat_size,
`ifdef PLAT_HFLIP_EN
  input  logic               plat_hflip,
  output logic               act_flip,
`endif
  input  logic               upd_req,
  output logic               upd_ack,
  output logic [COORD_W-1:0] act_x,
  output logic [COORD_W-1:0] act_y,
  output logic [7:0]         act_size
);
  upd_state_t state, state_n;
  logic cap, apply;
  logic [COORD_W-1:0] pend_x, pend_y;
  logic [7:0] pend_size;
`ifdef PLAT_HFLIP_EN
  logic pend_flip;
`endif
  // Requests are only taken in IDLE; the frame boundary commits them
  always_comb begin
    cap = (state == IDLE) && upd_req;
    apply = (state == PENDING) && frame_start;
    state_n = cap ? PENDING : apply ? APPLY : (state == APPLY) ? IDLE : state;
  end
  // State, pending/active parameter registers and registered acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      upd_ack <= 1'b0;
      pend_x <= '0;
      pend_y <= '0;
      pend_size <= '0;
      act_x <= '0;
      act_y <= '0;
      act_size <= '0;
`ifdef PLAT_HFLIP_EN
      pend_flip <= 1'b0;
      act_flip <= 1'b0;
`endif
    end else begin
      state <= state_n;
      upd_ack <= (state == APPLY);
      if (cap) begin
        pend_x <= plat_x;
        pend_y <= plat_y;
        pend_size <= plat_size;
`ifdef PLAT_HFLIP_EN
        pend_flip <= plat_hflip;
`endif
      end
      if (apply) begin
        act_x <= pend_x;
        act_y <= pend_y;
        act_size <= pend_size;
`ifdef PLAT_HFLIP_EN
        act_flip <= pend_flip;
`endif
      end
    end
  end
endmodule

// File: rtl/plat_addr_gen.sv
// plat_addr_gen: two-stage sprite ROM address / hit pipeline for a platform; PLAT_HFLIP_EN adds horizontal flip
module plat_addr_gen #(
  parameter int SPRITE_H = plat_pkg::SPRITE_H,
  parameter int COORD_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] plat_x,
  input  logic [COORD_W-1:0] plat_y,
  input  logic [7:0]         plat_size,
`ifdef PLAT_HFLIP_EN
  input  logic               plat_hflip,
`endif
  input  logic               upd_req,
  output logic               upd_ack,
  output logic [18:0]        read_address,
  output logic               plat_hit,
  output logic               out_valid
);
  import plat_pkg::*;
  logic [COORD_W-1:0] act_x, act_y;
  logic [7:0] act_size;
  size_dec_t dec;
  logic [COORD_W:0] dx, dy, w_ext;
  logic in_rng;
  logic v1, hit1;
  logic [COORD_W:0] dx1, dy1;
  logic [3:0] lg1;
  logic [18:0] row, col, addr_n;
`ifdef PLAT_HFLIP_EN
  logic act_flip, flip1;
`endif

  plat_upd_ctrl #(.COORD_W(COORD_W)) u_ctrl (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .plat_x(plat_x),
    .plat_y(plat_y),
    .plat_size(plat_size),
`ifdef PLAT_HFLIP_EN
    .plat_hflip(plat_hflip),
    .act_flip(act_flip),
`endif
    .upd_req(upd_req),
    .upd_ack(upd_ack),
    .act_x(act_x),
    .act_y(act_y),
    .act_size(act_size)
  );

  assign dec = size_log2(act_size);

  // Offsets are one bit wider than coordinates so the range test never sees a wrapped value
  always_comb begin
    dx = {1'b0, draw_x} - {1'b0, act_x};
    dy = {1'b0, draw_y} - {1'b0, act_y};
    w_ext = {{COORD_W{1'b0}}, 1'b1} << dec.lg;
    in_rng = dec.ok && (draw_x >= act_x) && (dx < w_ext) &&
             (draw_y >= act_y) && (dy < (COORD_W+1)'(SPRITE_H));
  end

  // Stage 1: register offsets, hit flag and the width exponent they were computed against
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      hit1 <= 1'b0;
      dx1 <= '0;
      dy1 <= '0;
      lg1 <= '0;
`ifdef PLAT_HFLIP_EN
      flip1 <= 1'b0;
`endif
    end else begin
      v1 <= pix_valid;
      hit1 <= in_rng;
      dx1 <= dx;
      dy1 <= dy;
      lg1 <= dec.lg;
`ifdef PLAT_HFLIP_EN
      flip1 <= act_flip;
`endif
    end
  end

  // Row offset by shift, column optionally mirrored; zero unless a valid hit
  always_comb begin
    row = 19'(dy1) << lg1;
`ifdef PLAT_HFLIP_EN
    col = flip1 ? ((19'd1 << lg1) - 19'd1 - 19'(dx1)) : 19'(dx1);
`else
    col = 19'(dx1);
`endif
    addr_n = (v1 && hit1) ? row + col : '0;
  end

  // Stage 2: output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      plat_hit <= 1'b0;
      read_address <= '0;
    end else begin
      out_valid <= v1;
      plat_hit <= v1 && hit1;
      read_address <= addr_n;
    end
  end
endmodule

// File: tb/tb_plat_addr_gen.sv
// tb_plat_addr_gen: randomized self-checking bench for plat_addr_gen against a behavioural model
module tb_plat_addr_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] draw_x = '0, draw_y = '0, plat_x = '0, plat_y = '0;
  logic [7:0] plat_size = '0;
  logic pix_valid = 1'b0, frame_start = 1'b0, upd_req = 1'b0;
  logic upd_ack, plat_hit, out_valid;
  logic [18:0] read_address;
`ifdef PLAT_HFLIP_EN
  logic plat_hflip = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  int m_x = 0, m_y = 0, m_size = 0, m_flip = 0;

  typedef struct packed {
    logic        v;
    logic        hit;
    logic [18:0] addr;
  } exp_t;

  plat_addr_gen dut (
    .clk(clk),
    .rst_n(rst_n),
    .draw_x(draw_x),
    .draw_y(draw_y),
    .pix_valid(pix_valid),
    .frame_start(frame_start),
    .plat_x(plat_x),
    .plat_y(plat_y),
    .plat_size(plat_size),
`ifdef PLAT_HFLIP_EN
    .plat_hflip(plat_hflip),
`endif
    .upd_req(upd_req),
    .upd_ack(upd_ack),
    .read_address(read_address),
    .plat_hit(plat_hit),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Platform is a W x 16 rectangle at (m_x,m_y); row-major address, optional mirrored column
  function automatic exp_t model(input int px, input int py, input bit pv);
    exp_t e;
    int w, dx;
    bit legal;
    w = 2 * m_size;
    legal = (m_size == 128) || (m_size == 64) || (m_size == 32) || (m_size == 16);
    e.v = pv;
    e.hit = pv && legal && px >= m_x && px < m_x + w && py >= m_y && py < m_y + 16;
    dx = (m_flip != 0) ? w - 1 - (px - m_x) : px - m_x;
    e.addr = e.hit ? 19'((py - m_y) * w + dx) : 19'd0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int x, input int y, input int s, input int f);
    int k;
    plat_x = 10'(x);
    plat_y = 10'(y);
    plat_size = 8'(s);
`ifdef PLAT_HFLIP_EN
    plat_hflip = f[0];
`endif
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    k = 0;
    while (upd_ack !== 1'b1 && k < 6) begin
      tick();
      k++;
    end
    checks++;
    if (upd_ack !== 1'b1) begin
      errors++;
      $display("FAIL load_ack: upd_ack=%b required 1 (x=%0d y=%0d size=%0d)", upd_ack, x, y, s);
    end
    m_x = x;
    m_y = y;
    m_size = s & 255;
    m_flip = f;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({out_valid, plat_hit, read_address, upd_ack} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b hit=%b addr=%0d ack=%b required all 0", out_valid, plat_hit, read_address, upd_ack);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_update();
    logic [3:0] acks;
    plat_x = 10'd100;
    plat_y = 10'd200;
    plat_size = 8'd64;
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    acks[0] = upd_ack;
    for (int i = 1; i < 4; i++) begin
      tick();
      acks[i] = upd_ack;
    end
    checks++;
    if (acks !== 4'b0010) begin
      errors++;
      $display("FAIL update_ack_timing: ack samples=%b required 0010 (cycles 1..4 after frame_start)", acks);
    end
    m_x = 100;
    m_y = 200;
    m_size = 64;
    m_flip = 0;
  endtask

  task automatic test_directed();
    int px[4] = '{110, 99, 228, 110};
    int py[4] = '{203, 203, 203, 216};
    logic [18:0] ea[4] = '{19'd394, 19'd0, 19'd0, 19'd0};
    logic eh[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      draw_x = 10'(px[i]);
      draw_y = 10'(py[i]);
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || plat_hit !== eh[i] || read_address !== ea[i]) begin
        errors++;
        $display("FAIL directed_pix(%0d,%0d): v=%b hit=%b addr=%0d required v=1 hit=%b addr=%0d",
                 px[i], py[i], out_valid, plat_hit, read_address, eh[i], ea[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic seen;
    exp_t e;
    int px[2] = '{310, 10};
    int py[2] = '{45, 10};
    seen = 1'b0;
    plat_x = 10'd300;
    plat_y = 10'd40;
    plat_size = 8'd32;
    upd_req = 1'b1;
    frame_start = 1'b1;
    tick();
    seen |= upd_ack;
    upd_req = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= upd_ack;
    end
    plat_x = 10'd5;
    plat_y = 10'd5;
    plat_size = 8'd128;
    upd_req = 1'b1;
    tick();
    seen |= upd_ack;
    upd_req = 1'b0;
    tick();
    seen |= upd_ack;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_early_ack: ack seen=%b required 0 before next frame_start", seen);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++;
    if (upd_ack !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_apply_ack: ack=%b required 1", upd_ack);
    end
    m_x = 300;
    m_y = 40;
    m_size = 32;
    m_flip = 0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= upd_ack;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL second_req_ignored: ack seen=%b required 0", seen);
    end
    for (int i = 0; i < 2; i++) begin
      draw_x = 10'(px[i]);
      draw_y = 10'(py[i]);
      pix_valid = 1'b1;
      e = model(px[i], py[i], 1'b1);
      tick();
      pix_valid = 1'b0;
      tick();
      checks++;
      if ({out_valid, plat_hit, read_address} !== e) begin
        errors++;
        $display("FAIL same_cycle_pix(%0d,%0d): v=%b hit=%b addr=%0d required v=%b hit=%b addr=%0d",
                 px[i], py[i], out_valid, plat_hit, read_address, e.v, e.hit, e.addr);
      end
    end
  endtask

  task automatic test_illegal();
    int px, py;
    load(100, 100, 200, 0);
    for (int i = 0; i < 8; i++) begin
      px = 100 + $urandom_range(0, 255);
      py = 100 + $urandom_range(0, 15);
      draw_x = 10'(px);
      draw_y = 10'(py);
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
      checks++;
      if (plat_hit !== 1'b0 || read_address !== 19'd0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL illegal_size_pix(%0d,%0d): v=%b hit=%b addr=%0d required v=1 hit=0 addr=0",
                 px, py, out_valid, plat_hit, read_address);
      end
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int x, y, s, f, w, px, py;
    bit pv;
    for (int p = 0; p < 24; p++) begin
      s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : (16 << $urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? 1023 - int'($urandom_range(0, 40)) : int'($urandom_range(0, 1023));
      y = ($urandom_range(0, 3) == 0) ? 1023 - int'($urandom_range(0, 12)) : int'($urandom_range(0, 1023));
      f = 0;
`ifdef PLAT_HFLIP_EN
      f = int'($urandom_range(0, 1));
`endif
      load(x, y, s, f);
      w = (m_size == 128 || m_size == 64 || m_size == 32 || m_size == 16) ? 2 * m_size : 64;
      q.delete();
      for (int i = 0; i < 40; i++) begin
        px = (x + int'($urandom_range(0, w + 3)) - 2) & 1023;
        py = (y + int'($urandom_range(0, 19)) - 2) & 1023;
        pv = ($urandom_range(0, 3) != 0);
        draw_x = 10'(px);
        draw_y = 10'(py);
        pix_valid = pv;
        q.push_back(model(px, py, pv));
        tick();
        if (q.size() > 1) begin
          e = q.pop_front();
          checks++;
          if ({out_valid, plat_hit, read_address} !== e) begin
            errors++;
            $display("FAIL random_stream plat(%0d,%0d,s=%0d,f=%0d): v=%b hit=%b addr=%0d required v=%b hit=%b addr=%0d",
                     x, y, s, f, out_valid, plat_hit, read_address, e.v, e.hit, e.addr);
          end
        end
      end
      pix_valid = 1'b0;
      tick();
      e = q.pop_front();
      checks++;
      if ({out_valid, plat_hit, read_address} !== e) begin
        errors++;
        $display("FAIL random_stream_tail: v=%b hit=%b addr=%0d required v=%b hit=%b addr=%0d",
                 out_valid, plat_hit, read_address, e.v, e.hit, e.addr);
      end
    end
  endtask

`ifdef PLAT_HFLIP_EN
  task automatic test_hflip();
    int px[2] = '{0, 5};
    int py[2] = '{0, 2};
    logic [18:0] ea[2] = '{19'd31, 19'd90};
    load(0, 0, 16, 1);
    for (int i = 0; i < 2; i++) begin
      draw_x = 10'(px[i]);
      draw_y = 10'(py[i]);
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
      checks++;
      if (plat_hit !== 1'b1 || read_address !== ea[i]) begin
        errors++;
        $display("FAIL hflip_pix(%0d,%0d): hit=%b addr=%0d required hit=1 addr=%0d",
                 px[i], py[i], plat_hit, read_address, ea[i]);
      end
    end
    load(0, 0, 16, 0);
  endtask
`endif

  task automatic test_reset_pending();
    logic seen;
    exp_t e;
    load(50, 60, 32, 0);
    draw_x = 10'd55;
    draw_y = 10'd61;
    pix_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || plat_hit !== 1'b1 || read_address !== 19'd69) begin
      errors++;
      $display("FAIL pre_reset_hit: v=%b hit=%b addr=%0d required v=1 hit=1 addr=69", out_valid, plat_hit, read_address);
    end
    plat_x = 10'd0;
    plat_y = 10'd0;
    plat_size = 8'd16;
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, plat_hit, read_address, upd_ack} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset_clear: v=%b hit=%b addr=%0d ack=%b required all 0", out_valid, plat_hit, read_address, upd_ack);
    end
    m_x = 0;
    m_y = 0;
    m_size = 0;
    m_flip = 0;
    tick();
    rst_n = 1'b1;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= upd_ack;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_discards_pending: ack seen=%b required 0", seen);
    end
    draw_x = 10'd0;
    draw_y = 10'd0;
    e = model(0, 0, 1'b1);
    tick();
    pix_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, plat_hit, read_address} !== e) begin
      errors++;
      $display("FAIL post_reset_no_draw: v=%b hit=%b addr=%0d required v=%b hit=%b addr=%0d",
               out_valid, plat_hit, read_address, e.v, e.hit, e.addr);
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_directed();
    test_same_cycle();
    test_illegal();
    test_random();
`ifdef PLAT_HFLIP_EN
    test_hflip();
`endif
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
